// File: rtl/cav14_fifo_reader.sv
// Read-side pointer controller for a 2^W-entry circular buffer with a
// one-cycle-latency memory; presents fetched entries on a valid/ready port.
module cav14_fifo_reader #(
  parameter int W  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W:0]    wr_ptr_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          out_ready_i,
  output logic          rd_en_o,
  output logic [W-1:0]  rd_addr_o,
  output logic [W:0]    rd_ptr_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic          empty_o,
  output logic [W:0]    count_o,
  output logic          prop_o
);

  // state | meaning
  // IDLE  | nothing held, waiting for wr_ptr to move ahead of rd_ptr
  // FETCH | read issued last cycle, mem_rdata lands at this edge
  // VALID | out_data holds an entry, waiting for out_ready
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  localparam logic [W:0] DEPTH = (W+1)'(1) << W;
  localparam logic [W:0] ONE   = (W+1)'(1);

  state_t        state_q, state_d;
  logic [W:0]    rd_ptr_q, rd_ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          rd_en;

  assign count_o = wr_ptr_i - rd_ptr_q;
  assign empty_o = (wr_ptr_i == rd_ptr_q);
  assign prop_o  = (count_o <= DEPTH);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_o) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + ONE;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        out_data_d  = mem_rdata_i;
        out_valid_d = 1'b1;
        state_d     = VALID;
      end
      VALID: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (!empty_o) begin
            rd_en    = 1'b1;
            rd_ptr_d = rd_ptr_q + ONE;
            state_d  = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Keep the strobe quiet while reset is held, even if the writer is ahead.
  assign rd_en_o     = rd_en && !rst;
  assign rd_addr_o   = rd_ptr_q[W-1:0];
  assign rd_ptr_o    = rd_ptr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  assert property (@(posedge clk) disable iff (rst) prop_o);

endmodule

// File: tb/tb_cav14_fifo_reader.sv
// Directed bench for cav14_fifo_reader: expected data/addresses queued at
// write time, popped by a negedge monitor on each read strobe and handshake.
module tb_cav14_fifo_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] wr_ptr = '0;
  logic [7:0] mem_rdata = '0;
  logic       out_ready = 1'b1;
  logic       rd_en, out_valid, empty, prop;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr, count;
  logic [7:0] out_data;

  logic [7:0] mem [16];
  logic [7:0] data_q [$];
  logic [3:0] addr_q [$];
  int         hs_q [$];
  int         cyc = 0;
  int         nvec = 0;
  int         nerr = 0;

  cav14_fifo_reader #(.W(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .wr_ptr_i(wr_ptr), .mem_rdata_i(mem_rdata),
    .out_ready_i(out_ready), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .rd_ptr_o(rd_ptr), .out_valid_o(out_valid), .out_data_o(out_data),
    .empty_o(empty), .count_o(count), .prop_o(prop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) mem_rdata <= mem[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe/handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("prop", prop, 1);
      if (rd_en) begin
        if (addr_q.size() == 0) chk("unexpected_rd_en", 1, 0);
        else chk("rd_addr", rd_addr, addr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        hs_q.push_back(cyc);
        if (data_q.size() == 0) chk("unexpected_output", 1, 0);
        else chk("out_data", out_data, data_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_ptr = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic write_entry(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    data_q.push_back(d);
    addr_q.push_back(wr_ptr[3:0]);
    wr_ptr = wr_ptr + 5'd1;
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      tick();
      if (data_q.size() == 0 && !out_valid && empty) break;
    end
    if (k == 200) chk({name, "_drain_timeout"}, 1, 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_rd_ptr", rd_ptr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
    end

    // Single entry with latency checks
    tick();
    out_ready = 1'b1;
    write_entry(8'hA5);
    @(negedge clk);
    chk("single_rd_en_t", rd_en, 1);
    chk("single_rd_addr_t", rd_addr, 0);
    @(negedge clk);
    chk("single_valid_t1", out_valid, 0);
    chk("single_rd_ptr_t1", rd_ptr, 1);
    @(negedge clk);
    chk("single_valid_t2", out_valid, 1);
    chk("single_data_t2", out_data, 8'hA5);
    tick();
    chk("single_idle_valid", out_valid, 0);
    chk("single_rd_ptr_end", rd_ptr, 1);

    // Backpressure then in-order delivery every 2 cycles
    do_reset();
    out_ready = 1'b0;
    write_entry(8'h11); tick();
    write_entry(8'h22); tick();
    write_entry(8'h33); tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data_held", out_data, 8'h11);
      chk("bp_rd_ptr", rd_ptr, 1);
      tick();
    end
    hs_q.delete();
    out_ready = 1'b1;
    drain("bp");
    chk("bp_hs_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      chk("bp_spacing_1", hs_q[1] - hs_q[0], 2);
      chk("bp_spacing_2", hs_q[2] - hs_q[1], 2);
    end
    chk("bp_rd_ptr_end", rd_ptr, 3);

    // Wrap: advance both pointers to 14, then cross the address wrap
    do_reset();
    for (int i = 0; i < 14; i++) begin
      write_entry(8'(8'h80 + i));
      tick();
    end
    drain("pre_wrap");
    chk("wrap_start_ptr", rd_ptr, 5'b01110);
    for (int i = 0; i < 4; i++) begin
      write_entry(8'(8'hC0 + i));
      tick();
    end
    drain("wrap");
    chk("wrap_end_ptr", rd_ptr, 5'b10010);

    // Full buffer: writer already 16 ahead when reset releases
    rst = 1'b1;
    tick();
    wr_ptr = '0;
    for (int i = 0; i < 16; i++) write_entry(8'(8'h40 + i));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("full_count", count, 16);
    chk("full_prop", prop, 1);
    drain("full");
    chk("full_empty_end", empty, 1);
    chk("full_rd_ptr_end", rd_ptr, 5'b10000);

    // Reset during FETCH drops the read; entry 0 is re-read afterwards
    do_reset();
    out_ready = 1'b1;
    write_entry(8'h5A);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rstf_out_valid", out_valid, 0);
    chk("rstf_rd_ptr", rd_ptr, 0);
    addr_q.push_front(4'd0);
    tick();
    chk("rstf_no_output", out_valid, 0);
    rst = 1'b0;
    drain("rstf");
    chk("rstf_rd_ptr_end", rd_ptr, 1);

    chk("data_q_empty", data_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
